// File: rtl/load_store_unit_if.sv
// Bus bundle for load_store_unit: pipeline request/response and the word-ported
// data memory port. The slave modport is the LSU's view; the master modport is
// the environment (pipeline plus memory).
interface load_store_unit_if;
    // Pipeline request
    logic        reqValid;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [31:0] reqAddr;
    logic [31:0] reqData;
    // Pipeline response
    logic        stall;
    logic [31:0] loadData;
    logic        loadValid;
    logic        misaligned;
    // Data memory port
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memReadData;

    modport slave (
        input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqData, memReadData,
        output stall, loadData, loadValid, misaligned,
        output memAddress, memWriteData, memRead, memWrite
    );

    modport master (
        output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqData, memReadData,
        input  stall, loadData, loadValid, misaligned,
        input  memAddress, memWriteData, memRead, memWrite
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store sequencer in front of a big-endian,
// word-ported data memory. Always issues word-aligned accesses, does
// read-modify-write for sub-word stores and extends sub-word load results.
// Optional feature macro: LSU_SUBWORD_EN (byte/halfword support). Without it only
// word accesses are legal and everything else is reported as misaligned.
module load_store_unit (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        WR_ISSUE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_q, state_d;
    logic        stall_q, stall_d;
    logic        load_valid_q, load_valid_d;
    logic        misaligned_q, misaligned_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] load_data_q, load_data_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;
    logic        legal;

`ifdef LSU_SUBWORD_EN
    // Captured request fields needed after the accept edge
    logic        req_write_q, req_write_d;
    logic [1:0]  req_size_q, req_size_d;
    logic        req_signed_q, req_signed_d;
    logic [1:0]  req_off_q, req_off_d;
    logic [15:0] req_data_q, req_data_d;

    // Pick the addressed byte/halfword out of a big-endian word and extend it
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (sz)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Overwrite only the addressed lane(s) of the word read back from memory
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] off, input logic [15:0] d);
        logic [31:0] r;
        r = w;
        if (sz == SZ_BYTE) begin
            case (off)
                2'd0:    r[31:24] = d[7:0];
                2'd1:    r[23:16] = d[7:0];
                2'd2:    r[15:8]  = d[7:0];
                default: r[7:0]   = d[7:0];
            endcase
        end else if (off[1]) begin
            r[15:0] = d;
        end else begin
            r[31:16] = d;
        end
        return r;
    endfunction
`else
    // Sign control has no meaning when only full words can be loaded
    logic unused_req_signed;
    assign unused_req_signed = bus.reqSigned;
`endif

    // Size/alignment legality of the request currently on the bus
    always_comb begin
        legal = 1'b0;
        case (bus.reqSize)
            SZ_WORD: legal = (bus.reqAddr[1:0] == 2'b00);
`ifdef LSU_SUBWORD_EN
            SZ_BYTE: legal = 1'b1;
            SZ_HALF: legal = ~bus.reqAddr[0];
`endif
            default: legal = 1'b0;
        endcase
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d          = state_q;
        load_valid_d     = 1'b0;
        misaligned_d     = 1'b0;
        mem_read_d       = 1'b0;
        mem_write_d      = 1'b0;
        load_data_d      = load_data_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
`ifdef LSU_SUBWORD_EN
        req_write_d      = req_write_q;
        req_size_d       = req_size_q;
        req_signed_d     = req_signed_q;
        req_off_d        = req_off_q;
        req_data_d       = req_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.reqValid) begin
                    if (!legal) begin
                        // Reject without touching memory; stay ready
                        misaligned_d = 1'b1;
                    end else begin
                        mem_address_d = {bus.reqAddr[31:2], 2'b00};
`ifdef LSU_SUBWORD_EN
                        req_write_d  = bus.reqWrite;
                        req_size_d   = bus.reqSize;
                        req_signed_d = bus.reqSigned;
                        req_off_d    = bus.reqAddr[1:0];
                        req_data_d   = bus.reqData[15:0];
`endif
                        // Word stores go straight out; sub-word stores read first
                        if (bus.reqWrite && bus.reqSize == SZ_WORD) begin
                            mem_write_data_d = bus.reqData;
                            mem_write_d      = 1'b1;
                            state_d          = WR_ISSUE;
                        end else begin
                            mem_read_d = 1'b1;
                            state_d    = RD_ISSUE;
                        end
                    end
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
`ifdef LSU_SUBWORD_EN
                if (req_write_q) begin
                    mem_write_data_d = merge(bus.memReadData, req_size_q, req_off_q, req_data_q);
                    mem_write_d      = 1'b1;
                    state_d          = WR_ISSUE;
                end else begin
                    load_data_d  = extract(bus.memReadData, req_size_q, req_off_q, req_signed_q);
                    load_valid_d = 1'b1;
                    state_d      = IDLE;
                end
`else
                load_data_d  = bus.memReadData;
                load_valid_d = 1'b1;
                state_d      = IDLE;
`endif
            end
            WR_ISSUE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        stall_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            stall_q          <= 1'b0;
            load_valid_q     <= 1'b0;
            misaligned_q     <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            load_data_q      <= '0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            stall_q          <= stall_d;
            load_valid_q     <= load_valid_d;
            misaligned_q     <= misaligned_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            load_data_q      <= load_data_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

`ifdef LSU_SUBWORD_EN
    // Request capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_write_q  <= 1'b0;
            req_size_q   <= SZ_WORD;
            req_signed_q <= 1'b0;
            req_off_q    <= 2'b00;
            req_data_q   <= '0;
        end else begin
            req_write_q  <= req_write_d;
            req_size_q   <= req_size_d;
            req_signed_q <= req_signed_d;
            req_off_q    <= req_off_d;
            req_data_q   <= req_data_d;
        end
    end
`endif

    assign bus.stall        = stall_q;
    assign bus.loadValid    = load_valid_q;
    assign bus.loadData     = load_data_q;
    assign bus.misaligned   = misaligned_q;
    assign bus.memRead      = mem_read_q;
    assign bus.memWrite     = mem_write_q;
    assign bus.memAddress   = mem_address_q;
    assign bus.memWriteData = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a synchronous word memory model and a
// load-result scoreboard. Handles both builds (LSU_SUBWORD_EN on or off).
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mem [16] = '{default: 32'h0};

    load_store_unit_if bus ();

    load_store_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Data memory: writes on the sampling edge, read data valid the next cycle
    always @(posedge clk) begin
        if (bus.memWrite) mem[bus.memAddress[5:2]] <= bus.memWriteData;
        if (bus.memRead)  bus.memReadData <= mem[bus.memAddress[5:2]];
    end

    task automatic chk(input string tag, input string what, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    // Scoreboard: every loadValid pulse must match the oldest expected load
    always @(negedge clk) begin
        if (bus.loadValid) begin
            if (exp_q.size() == 0) begin
                chk("sb", "unexpected_loadValid", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb", "loadData", bus.loadData, e);
            end
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.reqValid  = 1'b1;
        bus.reqWrite  = w;
        bus.reqSize   = sz;
        bus.reqSigned = sg;
        bus.reqAddr   = a;
        bus.reqData   = d;
        @(negedge clk);
        bus.reqValid  = 1'b0;
    endtask

    task automatic load(input string tag, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        issue(1'b0, sz, sg, a, 32'h0);
    endtask

    // Per-cycle strobe trace for 4 cycles after the accept edge (bit k = cycle k)
    task automatic trace(input string tag, input logic [3:0] e_rd, input logic [3:0] e_wr,
                         input logic [3:0] e_st, input logic [3:0] e_lv,
                         input logic [3:0] e_mis, input logic [31:0] e_addr,
                         input logic [31:0] e_wd);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk(tag, $sformatf("memRead[%0d]", k),    32'(bus.memRead),    32'(e_rd[k]));
            chk(tag, $sformatf("memWrite[%0d]", k),   32'(bus.memWrite),   32'(e_wr[k]));
            chk(tag, $sformatf("stall[%0d]", k),      32'(bus.stall),      32'(e_st[k]));
            chk(tag, $sformatf("loadValid[%0d]", k),  32'(bus.loadValid),  32'(e_lv[k]));
            chk(tag, $sformatf("misaligned[%0d]", k), 32'(bus.misaligned), 32'(e_mis[k]));
            if (e_wr[k]) chk(tag, "memWriteData", bus.memWriteData, e_wd);
            if (k == 0 && (e_rd[0] || e_wr[0])) chk(tag, "memAddress", bus.memAddress, e_addr);
        end
    endtask

    initial begin
        logic [31:0] cur_word;
        rst_n         = 1'b0;
        bus.reqValid  = 1'b0;
        bus.reqWrite  = 1'b0;
        bus.reqSize   = 2'b10;
        bus.reqSigned = 1'b0;
        bus.reqAddr   = '0;
        bus.reqData   = '0;

        #3;
        chk("reset", "stall",        32'(bus.stall),      32'd0);
        chk("reset", "loadValid",    32'(bus.loadValid),  32'd0);
        chk("reset", "misaligned",   32'(bus.misaligned), 32'd0);
        chk("reset", "memRead",      32'(bus.memRead),    32'd0);
        chk("reset", "memWrite",     32'(bus.memWrite),   32'd0);
        chk("reset", "loadData",     bus.loadData,        32'd0);
        chk("reset", "memAddress",   bus.memAddress,      32'd0);
        chk("reset", "memWriteData", bus.memWriteData,    32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Word store then word load at addr 8
        issue(1'b1, 2'b10, 1'b0, 32'd8, 32'h07FFDFF0);
        trace("st_w", 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 32'd8, 32'h07FFDFF0);
        load("ld_w", 2'b10, 1'b0, 32'd8, 32'h07FFDFF0);
        trace("ld_w", 4'b0001, 4'b0000, 4'b0011, 4'b0100, 4'b0000, 32'd8, 32'h0);
        cur_word = 32'h07FFDFF0;

        // Misaligned word, halfword and reserved size: no memory access, no stall
        issue(1'b0, 2'b10, 1'b0, 32'd6, 32'h0);
        trace("mis_w", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 32'h0, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'd11, 32'h0);
        trace("mis_h", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 32'h0, 32'h0);
        issue(1'b1, 2'b11, 1'b0, 32'd8, 32'h0);
        trace("mis_rsv", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 32'h0, 32'h0);

`ifdef LSU_SUBWORD_EN
        // Byte store read-modify-write, then loads of every flavour
        issue(1'b1, 2'b00, 1'b0, 32'd9, 32'h000000AA);
        trace("st_b", 4'b0001, 4'b0100, 4'b0111, 4'b0000, 4'b0000, 32'd8, 32'h07AADFF0);
        cur_word = 32'h07AADFF0;
        load("ld_w2", 2'b10, 1'b0, 32'd8, 32'h07AADFF0);
        trace("ld_w2", 4'b0001, 4'b0000, 4'b0011, 4'b0100, 4'b0000, 32'd8, 32'h0);
        load("ld_bs", 2'b00, 1'b1, 32'd9, 32'hFFFFFFAA);
        trace("ld_bs", 4'b0001, 4'b0000, 4'b0011, 4'b0100, 4'b0000, 32'd8, 32'h0);
        load("ld_bu", 2'b00, 1'b0, 32'd9, 32'h000000AA);
        trace("ld_bu", 4'b0001, 4'b0000, 4'b0011, 4'b0100, 4'b0000, 32'd8, 32'h0);
        load("ld_hs", 2'b01, 1'b1, 32'd10, 32'hFFFFDFF0);
        trace("ld_hs", 4'b0001, 4'b0000, 4'b0011, 4'b0100, 4'b0000, 32'd8, 32'h0);
        load("ld_hu0", 2'b01, 1'b0, 32'd8, 32'h000007AA);
        trace("ld_hu0", 4'b0001, 4'b0000, 4'b0011, 4'b0100, 4'b0000, 32'd8, 32'h0);
        load("ld_bs3", 2'b00, 1'b1, 32'd11, 32'hFFFFFFF0);
        trace("ld_bs3", 4'b0001, 4'b0000, 4'b0011, 4'b0100, 4'b0000, 32'd8, 32'h0);

        // Reset during WR_ISSUE of a byte store: the write must not happen
        issue(1'b1, 2'b00, 1'b0, 32'd9, 32'h00000055);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid", "memWrite_before", 32'(bus.memWrite), 32'd1);
        chk("rst_mid", "memWriteData",    bus.memWriteData,  32'h0755DFF0);
`else
        // Sub-word accesses are illegal in this build
        issue(1'b1, 2'b00, 1'b0, 32'd8, 32'h000000AA);
        trace("st_b_off", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 32'h0, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'd8, 32'h0);
        trace("ld_h_off", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 32'h0, 32'h0);
        load("ld_w_off", 2'b10, 1'b0, 32'd8, 32'h07FFDFF0);
        trace("ld_w_off", 4'b0001, 4'b0000, 4'b0011, 4'b0100, 4'b0000, 32'd8, 32'h0);

        // Reset during WR_ISSUE of a word store: the write must not happen
        issue(1'b1, 2'b10, 1'b0, 32'd8, 32'h12345678);
        chk("rst_mid", "memWrite_before", 32'(bus.memWrite), 32'd1);
`endif
        rst_n = 1'b0;
        #1;
        chk("rst_mid", "memWrite",  32'(bus.memWrite),  32'd0);
        chk("rst_mid", "stall",     32'(bus.stall),     32'd0);
        chk("rst_mid", "loadValid", 32'(bus.loadValid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load("rst_ld", 2'b10, 1'b0, 32'd8, cur_word);
        trace("rst_ld", 4'b0001, 4'b0000, 4'b0011, 4'b0100, 4'b0000, 32'd8, 32'h0);

        repeat (2) @(negedge clk);
        chk("sb", "pending_loads", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
